// File: rtl/simd_downstream_intf_pkg.sv
// Shared definitions for the stack-bus-to-SIMD deserializer (sdi):
// bus control/type encodings, FSM state encodings, and the beat-count helpers.
package simd_downstream_intf_pkg;

    // Stack bus control field encodings
    localparam logic [1:0] CNTL_SOM  = 2'b01;
    localparam logic [1:0] CNTL_MOM  = 2'b10;
    localparam logic [1:0] CNTL_EOM  = 2'b11;

    // Stack bus packet type encodings
    localparam logic [1:0] TYPE_NA   = 2'b00;
    localparam logic [1:0] TYPE_DATA = 2'b01;

    // FSM state encodings
    localparam logic [1:0] ST_WAIT   = 2'b00;
    localparam logic [1:0] ST_LOAD   = 2'b01;
    localparam logic [1:0] ST_FULL   = 2'b10;
    localparam logic [1:0] ST_ERROR  = 2'b11;

    // Beats needed to fill the whole lane array
    function automatic int sdi_num_xfers(input int lanes, input int lane_w, input int bus_w);
        return (lanes * lane_w) / bus_w;
    endfunction

    // Counter width covering beat indices 0 .. NUM_XFERS-1
    function automatic int sdi_cnt_w(input int xfers);
        return (xfers < 2) ? 1 : $clog2(xfers);
    endfunction

endpackage

// File: rtl/simd_downstream_intf_lane_demux.sv
// Beat-to-lane demux: turns a beat index and one bus beat into per-lane write
// enables and per-lane write data. Purely combinational. Each beat covers L
// consecutive lanes; the lowest lane of the group takes the low bits of the beat.
module simd_downstream_lane_demux #(
    parameter int NUM_LANES  = 32,
    parameter int LANE_WIDTH = 32,
    parameter int L          = 2,
    parameter int IDX_W      = 4
) (
    input  logic [IDX_W-1:0]                i_beat_idx,
    input  logic [L*LANE_WIDTH-1:0]         i_data,
    output logic [NUM_LANES-1:0]            o_lane_we,
    output logic [NUM_LANES*LANE_WIDTH-1:0] o_lane_data
);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        // Lane g belongs to beat g/L and sits at slot g%L within that beat
        assign o_lane_we[g] = (i_beat_idx == IDX_W'(g / L));
        assign o_lane_data[g*LANE_WIDTH +: LANE_WIDTH] = i_data[(g % L)*LANE_WIDTH +: LANE_WIDTH];
    end

endmodule

// File: rtl/simd_downstream_intf.sv
// simd_downstream_intf: receives one multi-beat stack-bus message (SOM, MOM..., EOM)
// and deserializes it into the SIMD lane register array, then holds the array
// and its tag until the SIMD reports consumption.
// Optional build macro SIMD_DOWNSTREAM_ERR_RECOVER_EN: ERROR becomes recoverable
// (drain to EOM or restart on SOM), error becomes a per-error pulse, and an
// 8-bit saturating error counter port is added.
module simd_downstream_intf
    import simd_downstream_intf_pkg::*;
#(
    parameter int NUM_LANES  = 32,
    parameter int LANE_WIDTH = 32,
    parameter int BUS_WIDTH  = 64,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            reset_poweron,
    input  logic                            sti__sdi__valid,
    input  logic [1:0]                      sti__sdi__cntl,
    input  logic [1:0]                      sti__sdi__type,
    input  logic [BUS_WIDTH-1:0]            sti__sdi__data,
    input  logic [TAG_WIDTH-1:0]            sti__sdi__oob_data,
    output logic                            sdi__sti__ready,
    output logic [NUM_LANES-1:0]            sdi__simd__regs_valid,
    output logic [NUM_LANES*LANE_WIDTH-1:0] sdi__simd__regs,
    output logic [TAG_WIDTH-1:0]            sdi__simd__tag,
    input  logic                            simd__sdi__regs_complete,
    output logic                            sdi__simd__error
`ifdef SIMD_DOWNSTREAM_ERR_RECOVER_EN
    ,
    output logic [7:0]                      sdi__simd__err_count
`endif
);

    localparam int NUM_XFERS = sdi_num_xfers(NUM_LANES, LANE_WIDTH, BUS_WIDTH);
    localparam int L         = BUS_WIDTH / LANE_WIDTH;
    localparam int CNT_W     = sdi_cnt_w(NUM_XFERS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_XFERS - 1);

    logic [1:0]                      r_state;
    logic [CNT_W-1:0]                r_count;
    logic                            r_ready;
    logic [NUM_LANES-1:0]            r_regs_valid;
    logic [NUM_LANES*LANE_WIDTH-1:0] r_regs;
    logic [TAG_WIDTH-1:0]            r_tag;
    logic                            r_error;

    logic [1:0]                      w_state_next;
    logic                            w_accept;
    logic                            w_start;   // SOM+DATA opening a new message
    logic                            w_write;   // accepted beat lands in the lanes
    logic                            w_last;    // accepted beat is the closing EOM
    logic                            w_err;     // protocol violation this cycle
    logic                            w_ready_next;
    logic [CNT_W-1:0]                w_beat_idx;
    logic [NUM_LANES-1:0]            w_lane_we;
    logic [NUM_LANES*LANE_WIDTH-1:0] w_lane_data;

    assign w_accept   = sti__sdi__valid & r_ready;
    assign w_beat_idx = w_start ? '0 : r_count;

    // Next-state decode and beat classification
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_write      = 1'b0;
        w_last       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (w_accept) begin
                    if (sti__sdi__cntl != CNTL_SOM)
                        w_err = 1'b1;
                    else if (sti__sdi__type == TYPE_DATA)
                        w_start = 1'b1;
                    // non-DATA SOM is silently dropped
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    if (sti__sdi__cntl == CNTL_MOM && r_count != LAST_BEAT) begin
                        w_write = 1'b1;
                    end else if (sti__sdi__cntl == CNTL_EOM && r_count == LAST_BEAT) begin
                        w_write = 1'b1;
                        w_last  = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_FULL: begin
                if (simd__sdi__regs_complete)
                    w_state_next = ST_WAIT;
            end
            default: begin
`ifdef SIMD_DOWNSTREAM_ERR_RECOVER_EN
                // Drain the broken message: SOM restarts, EOM returns to idle
                if (w_accept) begin
                    if (sti__sdi__cntl == CNTL_SOM && sti__sdi__type == TYPE_DATA)
                        w_start = 1'b1;
                    else if (sti__sdi__cntl == CNTL_EOM)
                        w_state_next = ST_WAIT;
                end
`endif
            end
        endcase
        if (w_start) begin
            w_write      = 1'b1;
            w_state_next = ST_LOAD;
        end
        if (w_last)
            w_state_next = ST_FULL;
        if (w_err)
            w_state_next = ST_ERROR;
    end

`ifdef SIMD_DOWNSTREAM_ERR_RECOVER_EN
    assign w_ready_next = (w_state_next != ST_FULL);
`else
    assign w_ready_next = (w_state_next == ST_WAIT) | (w_state_next == ST_LOAD);
`endif

    simd_downstream_lane_demux #(
        .NUM_LANES  (NUM_LANES),
        .LANE_WIDTH (LANE_WIDTH),
        .L          (L),
        .IDX_W      (CNT_W)
    ) u_demux (
        .i_beat_idx  (w_beat_idx),
        .i_data      (sti__sdi__data),
        .o_lane_we   (w_lane_we),
        .o_lane_data (w_lane_data)
    );

    // Control state: FSM, beat count, ready, lane-valid, tag, error flag
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            r_state      <= ST_WAIT;
            r_count      <= '0;
            r_ready      <= 1'b0;
            r_regs_valid <= '0;
            r_tag        <= '0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ready      <= w_ready_next;
            r_regs_valid <= {NUM_LANES{w_state_next == ST_FULL}};
            if (w_start) begin
                r_tag   <= sti__sdi__oob_data;
                r_count <= CNT_W'(1);
            end else if (w_write && !w_last) begin
                r_count <= r_count + 1'b1;
            end else if (w_err || (r_state == ST_FULL && simd__sdi__regs_complete)) begin
                r_count <= '0;
            end
`ifdef SIMD_DOWNSTREAM_ERR_RECOVER_EN
            r_error <= w_err;
`else
            r_error <= (w_state_next == ST_ERROR);
`endif
        end
    end

    // Lane registers: written beat by beat, retained after consumption
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            r_regs <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_write && w_lane_we[i])
                    r_regs[i*LANE_WIDTH +: LANE_WIDTH] <= w_lane_data[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

`ifdef SIMD_DOWNSTREAM_ERR_RECOVER_EN
    logic [7:0] r_err_count;

    // Saturating count of protocol errors
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron)
            r_err_count <= '0;
        else if (w_err && r_err_count != 8'hFF)
            r_err_count <= r_err_count + 8'd1;
    end

    assign sdi__simd__err_count = r_err_count;
`endif

    assign sdi__sti__ready       = r_ready;
    assign sdi__simd__regs_valid = r_regs_valid;
    assign sdi__simd__regs       = r_regs;
    assign sdi__simd__tag        = r_tag;
    assign sdi__simd__error      = r_error;

endmodule

// File: tb/tb_simd_downstream_intf.sv
// Directed bench for simd_downstream_intf: table of single-beat protocol vectors
// plus hand-written multi-cycle sequences (nominal load, backpressure, async reset,
// and the recovery build when SIMD_DOWNSTREAM_ERR_RECOVER_EN is defined).
module tb_simd_downstream_intf;
    import simd_downstream_intf_pkg::*;

    localparam int NL = 32;
    localparam int LW = 32;
    localparam int BW = 64;
    localparam int TW = 8;
    localparam int NX = 16;
`ifdef SIMD_DOWNSTREAM_ERR_RECOVER_EN
    localparam bit REC = 1'b1;
`else
    localparam bit REC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            vld = 1'b0;
    logic [1:0]      cntl = 2'b00;
    logic [1:0]      typ = 2'b00;
    logic [BW-1:0]   data = '0;
    logic [TW-1:0]   oob = '0;
    logic            cmpl = 1'b0;
    logic            ready;
    logic [NL-1:0]   rv;
    logic [NL*LW-1:0] regs;
    logic [TW-1:0]   tag;
    logic            err;
`ifdef SIMD_DOWNSTREAM_ERR_RECOVER_EN
    logic [7:0]      err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    simd_downstream_intf #(.NUM_LANES(NL), .LANE_WIDTH(LW), .BUS_WIDTH(BW), .TAG_WIDTH(TW)) dut (
        .clk                      (clk),
        .reset_poweron            (rst),
        .sti__sdi__valid          (vld),
        .sti__sdi__cntl           (cntl),
        .sti__sdi__type           (typ),
        .sti__sdi__data           (data),
        .sti__sdi__oob_data       (oob),
        .sdi__sti__ready          (ready),
        .sdi__simd__regs_valid    (rv),
        .sdi__simd__regs          (regs),
        .sdi__simd__tag           (tag),
        .simd__sdi__regs_complete (cmpl),
        .sdi__simd__error         (err)
`ifdef SIMD_DOWNSTREAM_ERR_RECOVER_EN
        ,
        .sdi__simd__err_count     (err_cnt)
`endif
    );

    // ph: 0 = normal receive, 1 = cycle error first appears, 2 = stuck in error
    typedef struct {
        logic        rst;
        logic [1:0]  cntl;
        logic [1:0]  typ;
        logic [7:0]  oob;
        int          ph;
        logic [7:0]  exp_tag;
        string       nm;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [1:0] c, input logic [1:0] t,
                       input logic [7:0] o, input int ph, input logic [7:0] et, input string nm);
        vec_t v;
        v.rst = r; v.cntl = c; v.typ = t; v.oob = o; v.ph = ph; v.exp_tag = et; v.nm = nm;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1ns after the edge
    task automatic cyc(input logic v, input logic [1:0] c, input logic [1:0] t,
                       input logic [BW-1:0] d, input logic [7:0] o, input logic cm);
        vld = v; cntl = c; typ = t; data = d; oob = o; cmpl = cm;
        @(posedge clk); #1;
        vld = 1'b0; cmpl = 1'b0;
    endtask

    task automatic do_reset();
        vld = 1'b0; cmpl = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Send nb beats of a message whose lane i will hold base+i
    task automatic send_msg(input logic [7:0] t, input int base, input int nb);
        logic ok;
        logic [1:0] c;
        ok = 1'b1;
        for (int k = 0; k < nb; k++) begin
            c = (k == 0) ? CNTL_SOM : (k == NX-1) ? CNTL_EOM : CNTL_MOM;
            cyc(1'b1, c, TYPE_DATA, {32'(base + 2*k + 1), 32'(base + 2*k)}, t, 1'b0);
            if (k < NX-1 && !(ready === 1'b1 && rv === '0)) ok = 1'b0;
        end
        chk("ready_during_msg", ok, 1'b1);
    endtask

    task automatic chk_lanes(input string nm, input int base);
        int bad;
        bad = -1;
        for (int i = NL-1; i >= 0; i--)
            if (regs[i*LW +: LW] !== 32'(base + i)) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s lane=%0d actual=%0h expected=%0h", nm, bad,
                     regs[bad*LW +: LW], 32'(base + bad));
        end
    endtask

    initial begin
        // ---- protocol vector table ----
        // early EOM at beat 7
        add(1, CNTL_SOM, TYPE_DATA, 8'h11, 0, 8'h11, "eeom_som");
        for (int k = 1; k < 7; k++) add(0, CNTL_MOM, TYPE_DATA, 8'h00, 0, 8'h11, "eeom_mom");
        add(0, CNTL_EOM, TYPE_DATA, 8'h00, 1, 8'h11, "eeom_err");
        add(0, CNTL_MOM, TYPE_DATA, 8'h00, 2, 8'h11, "eeom_hold");
        add(0, CNTL_MOM, TYPE_DATA, 8'h00, 2, 8'h11, "eeom_hold2");
        // SOM inside LOAD at beat 3
        add(1, CNTL_SOM, TYPE_DATA, 8'h22, 0, 8'h22, "lsom_som");
        add(0, CNTL_MOM, TYPE_DATA, 8'h00, 0, 8'h22, "lsom_mom1");
        add(0, CNTL_MOM, TYPE_DATA, 8'h00, 0, 8'h22, "lsom_mom2");
        add(0, CNTL_SOM, TYPE_DATA, 8'h33, 1, 8'h22, "lsom_err");
        add(0, CNTL_MOM, TYPE_DATA, 8'h00, 2, 8'h22, "lsom_hold");
        // MOM / EOM while waiting
        add(1, CNTL_MOM, TYPE_DATA, 8'h44, 1, 8'h00, "wmom_err");
        add(0, CNTL_MOM, TYPE_DATA, 8'h00, 2, 8'h00, "wmom_hold");
        add(1, CNTL_EOM, TYPE_DATA, 8'h44, 1, 8'h00, "weom_err");
        // non-DATA SOM dropped, then a proper SOM starts
        add(1, CNTL_SOM, TYPE_NA,   8'h44, 0, 8'h00, "nsom_drop");
        add(0, CNTL_SOM, TYPE_DATA, 8'h55, 0, 8'h55, "nsom_start");
        add(0, CNTL_MOM, TYPE_DATA, 8'h00, 0, 8'h55, "nsom_mom");
        // MOM where the final EOM belongs
        add(1, CNTL_SOM, TYPE_DATA, 8'h66, 0, 8'h66, "lmom_som");
        for (int k = 1; k < NX-1; k++) add(0, CNTL_MOM, TYPE_DATA, 8'h00, 0, 8'h66, "lmom_mom");
        add(0, CNTL_MOM, TYPE_DATA, 8'h00, 1, 8'h66, "lmom_err");

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1'b0);
        chk("rst_rv", rv, '0);
        chk("rst_err", err, 1'b0);
        chk("rst_tag", tag, 8'h00);
        chk("rst_regs", (regs == '0), 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", ready, 1'b1);

        // ---- nominal message ----
        send_msg(8'h5A, 0, NX);
        chk("nom_rv", rv, {NL{1'b1}});
        chk("nom_ready", ready, 1'b0);
        chk("nom_tag", tag, 8'h5A);
        chk("nom_err", err, 1'b0);
        chk_lanes("nom_lanes", 0);

        // ---- backpressure while FULL ----
        for (int k = 0; k < 3; k++)
            cyc(1'b1, CNTL_SOM, TYPE_DATA, {BW{1'b1}}, 8'hA5, 1'b0);
        chk("bp_ready", ready, 1'b0);
        chk("bp_tag", tag, 8'h5A);
        chk("bp_rv", rv, {NL{1'b1}});
        chk_lanes("bp_lanes", 0);
        cyc(1'b0, CNTL_MOM, TYPE_DATA, '0, 8'h00, 1'b1);
        chk("cmpl_rv", rv, '0);
        chk("cmpl_ready", ready, 1'b1);
        chk("cmpl_retain", regs[5*LW +: LW], 32'd5);
        cyc(1'b0, CNTL_MOM, TYPE_DATA, '0, 8'h00, 1'b1);
        chk("stray_cmpl_ready", ready, 1'b1);
        chk("stray_cmpl_rv", rv, '0);
        send_msg(8'hA5, 100, NX);
        chk("msg2_tag", tag, 8'hA5);
        chk("msg2_rv", rv, {NL{1'b1}});
        chk_lanes("msg2_lanes", 100);
        cyc(1'b0, CNTL_MOM, TYPE_DATA, '0, 8'h00, 1'b1);

        // ---- table-driven protocol vectors ----
        for (int i = 0; i < tbl.size(); i++) begin
            logic er, ee;
            if (tbl[i].rst) do_reset();
            cyc(1'b1, tbl[i].cntl, tbl[i].typ, {32'(i), 32'(i + 7)}, tbl[i].oob, 1'b0);
            er = (tbl[i].ph == 0) ? 1'b1 : REC;
            ee = (tbl[i].ph == 1) ? 1'b1 : (tbl[i].ph == 2) ? !REC : 1'b0;
            chk({tbl[i].nm, "_ready"}, ready, er);
            chk({tbl[i].nm, "_err"}, err, ee);
            chk({tbl[i].nm, "_rv"}, rv, '0);
            chk({tbl[i].nm, "_tag"}, tag, tbl[i].exp_tag);
        end

        // ---- async reset mid-message ----
        do_reset();
        send_msg(8'h77, 200, 10);
        chk("pre_rst_lane0", regs[LW-1:0], 32'd200);
        rst = 1'b1;
        #2;
        chk("arst_ready", ready, 1'b0);
        chk("arst_tag", tag, 8'h00);
        chk("arst_lane0", regs[LW-1:0], 32'd0);
        chk("arst_lane19", regs[19*LW +: LW], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_ready_back", ready, 1'b1);
        send_msg(8'h78, 300, NX);
        chk("arst_msg_rv", rv, {NL{1'b1}});
        chk("arst_msg_tag", tag, 8'h78);
        chk_lanes("arst_msg_lanes", 300);

`ifdef SIMD_DOWNSTREAM_ERR_RECOVER_EN
        // ---- recovery: error, drain with EOM, then a clean message ----
        do_reset();
        cyc(1'b1, CNTL_MOM, TYPE_DATA, '0, 8'h00, 1'b0);
        chk("rec_err_pulse", err, 1'b1);
        chk("rec_cnt1", err_cnt, 8'd1);
        cyc(1'b1, CNTL_EOM, TYPE_DATA, '0, 8'h00, 1'b0);
        chk("rec_err_low", err, 1'b0);
        chk("rec_ready", ready, 1'b1);
        send_msg(8'h3C, 400, NX);
        chk("rec_msg_rv", rv, {NL{1'b1}});
        chk("rec_msg_tag", tag, 8'h3C);
        chk_lanes("rec_msg_lanes", 400);
        chk("rec_cnt_hold", err_cnt, 8'd1);
        cyc(1'b0, CNTL_MOM, TYPE_DATA, '0, 8'h00, 1'b1);
        // ---- saturation ----
        for (int k = 0; k < 300; k++) begin
            cyc(1'b1, CNTL_MOM, TYPE_DATA, '0, 8'h00, 1'b0);
            cyc(1'b1, CNTL_EOM, TYPE_DATA, '0, 8'h00, 1'b0);
        end
        chk("rec_cnt_sat", err_cnt, 8'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #500000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
